// File: rtl/fetch_decode_queue_if.sv
// IF -> queue -> ID handshake bundle for the fetch/decode instruction queue.
interface fetch_decode_queue_if #(
    parameter int unsigned PC_BITS     = 32,
    parameter int unsigned INSTR_BITS  = 32,
    parameter int unsigned INSTR_COUNT = 2,
    parameter int unsigned DEPTH       = 8
);
    localparam int unsigned PACKET_SIZE = PC_BITS + INSTR_BITS + 1;
    localparam int unsigned CNT_W       = $clog2(DEPTH) + 1;

    logic                                 flush_i;
    logic [INSTR_COUNT-1:0]               valid_i;
    logic [INSTR_COUNT*PACKET_SIZE-1:0]   packet_i;
    logic                                 ready_o;
    logic [INSTR_COUNT-1:0]               valid_o;
    logic [INSTR_COUNT*PACKET_SIZE-1:0]   packet_o;
    logic                                 ready_i;
    logic [CNT_W-1:0]                     count_o;

    // Queue side
    modport slave (
        input  flush_i, valid_i, packet_i, ready_i,
        output ready_o, valid_o, packet_o, count_o
    );

    // IF/ID side (driver)
    modport master (
        output flush_i, valid_i, packet_i, ready_i,
        input  ready_o, valid_o, packet_o, count_o
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Elastic instruction queue between IF and ID: two-wide push, two-wide pop,
// strict program order, full drop on flush.
module fetch_decode_queue #(
    parameter int unsigned PC_BITS     = 32,
    parameter int unsigned INSTR_BITS  = 32,
    parameter int unsigned INSTR_COUNT = 2,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_decode_queue_if.slave   fdq_if
);
    localparam int unsigned PACKET_SIZE = PC_BITS + INSTR_BITS + 1;
    localparam int unsigned PTR_W       = $clog2(DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned READY_MAX   = DEPTH - INSTR_COUNT;

    logic [PACKET_SIZE-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       head_p1_c, tail_p1_c;
    logic [1:0]             push_n_c, pop_n_c;
    logic [1:0]             valid_c;
    logic                   ready_c;

    // Handshake decode and next-state pointer/occupancy computation
    always_comb begin
        ready_c   = (count_q <= CNT_W'(READY_MAX));
        valid_c   = 2'b00;
        push_n_c  = 2'd0;
        pop_n_c   = 2'd0;
        head_p1_c = head_q + PTR_W'(1);
        tail_p1_c = tail_q + PTR_W'(1);

        if (count_q >= CNT_W'(2)) begin
            valid_c = 2'b11;
        end else if (count_q == CNT_W'(1)) begin
            valid_c = 2'b01;
        end

        // Illegal 10 falls through to no push
        if (ready_c && !fdq_if.flush_i) begin
            case (fdq_if.valid_i)
                2'b01:   push_n_c = 2'd1;
                2'b11:   push_n_c = 2'd2;
                default: push_n_c = 2'd0;
            endcase
        end

        if (fdq_if.ready_i && !fdq_if.flush_i) begin
            case (valid_c)
                2'b01:   pop_n_c = 2'd1;
                2'b11:   pop_n_c = 2'd2;
                default: pop_n_c = 2'd0;
            endcase
        end

        head_d  = head_q + PTR_W'(pop_n_c);
        tail_d  = tail_q + PTR_W'(push_n_c);
        count_d = count_q + CNT_W'(push_n_c) - CNT_W'(pop_n_c);

        // Flush drops everything, including same-cycle push and pop
        if (fdq_if.flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Packet storage; contents are not reset, occupancy guards reads
    always_ff @(posedge clk) begin
        if (push_n_c != 2'd0) begin
            mem_q[tail_q] <= fdq_if.packet_i[PACKET_SIZE-1:0];
        end
        if (push_n_c == 2'd2) begin
            mem_q[tail_p1_c] <= fdq_if.packet_i[2*PACKET_SIZE-1:PACKET_SIZE];
        end
    end

    assign fdq_if.ready_o  = ready_c;
    assign fdq_if.valid_o  = valid_c;
    assign fdq_if.packet_o = {mem_q[head_p1_c], mem_q[head_q]};
    assign fdq_if.count_o  = count_q;

    // Occupancy bound, push only when ready, no illegal slot pattern from IF
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(DEPTH));
    a_push_ready: assert property (@(posedge clk) disable iff (rst)
        (push_n_c != 2'd0) |-> ready_c);
    a_valid_legal: assert property (@(posedge clk) disable iff (rst)
        fdq_if.valid_i != 2'b10);

endmodule
